// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared APB address map and bus-phase encoding for the bridge slice
package apb_bridge_pkg;
  localparam int ADDR_WIDTH = 10;
  localparam logic [ADDR_WIDTH-1:0] DATA_ADDR = 10'h000;
  localparam logic [ADDR_WIDTH-1:0] CONFIG_ADDR = 10'h004;
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = 10'h008;
  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_t;
endpackage

// File: rtl/apb_rr_master_if.sv
// apb_rr_master_if: APB bus between the round-robin master and its register slave
interface apb_rr_master_if;
  logic [apb_bridge_pkg::ADDR_WIDTH-1:0] paddr;
  logic pwrite;
  logic [31:0] pwdata;
  logic [3:0] pstrb;
  logic psel;
  logic penable;
  logic [31:0] prdata;
  logic pready;
  logic pslverr;
  modport master (output paddr, pwrite, pwdata, pstrb, psel, penable, input prdata, pready, pslverr);
  modport slave (input paddr, pwrite, pwdata, pstrb, psel, penable, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_rr_master_arb.sv
// rr_arbiter: combinational rotate-priority pick, scanning from ptr+1 with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       valid
);
  int idx;
  always_comb begin
    grant = '0;
    idx = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx] && grant == '0) grant[idx] = 1'b1;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one bus among NUM_REQ requesters.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_rr_master import apb_bridge_pkg::*; #(
  parameter int NUM_REQ = 4
`ifdef APB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]         req_wdata,
  input  logic [NUM_REQ*4-1:0]          req_strb,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [31:0]                   rdata,
  output logic                          err,
  apb_rr_master_if.master               apb
);
  localparam int PW = $clog2(NUM_REQ);
  apb_state_t state, state_nxt;
  logic [PW-1:0] ptr, win;
  logic [NUM_REQ-1:0] arb_gnt;
  logic arb_valid, tmo, fin;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(req), .ptr(ptr), .grant(arb_gnt), .valid(arb_valid));
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) if (arb_gnt[i]) win = PW'(i);
  end
  assign fin = state == APB_ACCESS && (apb.pready || tmo);
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (state == APB_ACCESS && !fin) ? cnt + 1'b1 : '0;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= APB_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == APB_IDLE ? (arb_valid ? APB_SETUP : APB_IDLE) :
                state == APB_SETUP ? APB_ACCESS : fin ? APB_IDLE : APB_ACCESS;
  // ptr doubles as the current owner while a transfer is in flight
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ptr <= PW'(NUM_REQ - 1);
      apb.paddr <= '0;
      apb.pwrite <= 1'b0;
      apb.pwdata <= '0;
      apb.pstrb <= '0;
    end else if (state == APB_IDLE && arb_valid) begin
      ptr <= win;
      apb.paddr <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
      apb.pwrite <= req_write[win];
      apb.pwdata <= req_write[win] ? req_wdata[win*32 +: 32] : '0;
      apb.pstrb <= req_strb[win*4 +: 4];
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      done <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      done <= fin ? NUM_REQ'(1) << ptr : '0;
      if (fin) begin
        rdata <= (apb.pwrite || !apb.pready) ? '0 : apb.prdata;
        err <= !apb.pready || apb.pslverr;
      end
    end
  always_comb begin
    apb.psel = state != APB_IDLE;
    apb.penable = state == APB_ACCESS;
    gnt = (state != APB_IDLE || |done) ? NUM_REQ'(1) << ptr : '0;
  end
endmodule
